// File: rtl/ahb_write_buffer_if.sv
// AHB-lite slave port plus consumer handshake for ahb_write_buffer; all bus-side signals in one bundle.
// slave = buffer side, master = bus/consumer driver side.
interface ahb_write_buffer_if #(
    parameter int DWIDTH = 32
);
    logic              HSEL;
    logic [31:0]       HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic              HREADY;
    logic [31:0]       HWDATA;
    logic              HREADYOUT;
    logic              HRESP;
    logic [31:0]       HRDATA;
    logic [DWIDTH-1:0] YDATA;
    logic              YREQ;
    logic              YACK;
    logic              YPARITY;
    logic              full;
    logic              empty;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA, YACK,
        output HREADYOUT, HRESP, HRDATA, YDATA, YREQ, YPARITY, full, empty
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA, YACK,
        input  HREADYOUT, HRESP, HRDATA, YDATA, YREQ, YPARITY, full, empty
    );
endinterface

// File: rtl/ahb_write_buffer.sv
// AHB write FIFO drained by a REQ/ACK consumer; pushes land in the data phase, head visible 1 cycle after push.
// Writes to 0x0 stall (HREADYOUT=0) only while full with no same-cycle pop; WBUF_PARITY_EN adds per-entry parity.
module ahb_write_buffer #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4
) (
    input  logic clk,
    input  logic HRESETn,
    ahb_write_buffer_if.slave bus
);
    localparam int DEPTH = 1 << AWIDTH;
    localparam int OW    = AWIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;
    logic [OW-1:0]     r_occ;
    logic              r_dp_vld;
    logic              r_dp_write;
    logic [1:0]        r_dp_off;
    logic [15:0]       r_cycle_cnt;
    logic [15:0]       r_full_cnt;
    state_t            r_state;
    state_t            w_state_nxt;

    logic              w_full;
    logic              w_empty;
    logic              w_ap_vld;
    logic              w_wr0;
    logic              w_stall;
    logic              w_push;
    logic              w_pop;
    logic              w_clr;
    logic              w_yreq;
    logic              w_ypar;
    logic              w_pc25;
    logic              w_pc50;
    logic              w_pc75;
    logic [7:0]        w_occ8;
    logic [15:0]       w_perr_cnt;
    logic [DWIDTH-1:0] w_head;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_unused = ^{bus.HSIZE, bus.HADDR[31:4], bus.HADDR[1:0], bus.HWDATA};

    assign w_full   = (r_occ == OW'(DEPTH));
    assign w_empty  = (r_occ == '0);
    assign w_ap_vld = bus.HSEL & bus.HREADY & bus.HTRANS[1];

    // A pop in the same cycle frees the slot a stalled push is waiting for.
    assign w_pop   = (r_state == ST_REQ) & bus.YACK & ~w_empty;
    assign w_wr0   = r_dp_vld & r_dp_write & (r_dp_off == 2'd0);
    assign w_stall = w_wr0 & w_full & ~w_pop;
    assign w_push  = w_wr0 & ~w_stall;
    assign w_clr   = r_dp_vld & r_dp_write & (r_dp_off == 2'd1);

    assign w_pc25 = (r_occ >= OW'(DEPTH / 4));
    assign w_pc50 = (r_occ >= OW'(DEPTH / 2));
    assign w_pc75 = (r_occ >= OW'((3 * DEPTH) / 4));
    assign w_occ8 = 8'(r_occ);
    assign w_head = r_mem[r_rd_ptr];

    // Address-phase capture; held while the bus is stalled.
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dp_vld   <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_off   <= 2'd0;
        end else if (bus.HREADY) begin
            r_dp_vld   <= w_ap_vld;
            r_dp_write <= bus.HWRITE;
            r_dp_off   <= bus.HADDR[3:2];
        end
    end

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.HWDATA[DWIDTH-1:0];
    end

`ifdef WBUF_PARITY_EN
    logic        r_par [DEPTH];
    logic [15:0] r_perr_cnt;

    always_ff @(posedge clk) begin
        if (w_push) r_par[r_wr_ptr] <= ^bus.HWDATA[DWIDTH-1:0];
    end

    assign w_ypar = w_yreq & (^w_head ^ r_par[r_rd_ptr]);

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            r_perr_cnt <= '0;
        end else if (w_clr) begin
            r_perr_cnt <= '0;
        end else if (w_pop && w_ypar && r_perr_cnt != 16'hFFFF) begin
            r_perr_cnt <= r_perr_cnt + 16'd1;
        end
    end

    assign w_perr_cnt = r_perr_cnt;
`else
    assign w_ypar     = 1'b0;
    assign w_perr_cnt = 16'd0;
`endif

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cycle_cnt <= '0;
            r_full_cnt  <= '0;
        end else if (w_clr) begin
            r_cycle_cnt <= '0;
            r_full_cnt  <= '0;
        end else begin
            if (r_cycle_cnt != 16'hFFFF)          r_cycle_cnt <= r_cycle_cnt + 16'd1;
            if (w_full && r_full_cnt != 16'hFFFF) r_full_cnt  <= r_full_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // YACK only matters in REQ; RELEASE waits for it to drop so one ACK pulse never pops twice.
    always_comb begin
        w_state_nxt = r_state;
        w_yreq      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                w_yreq = 1'b1;
                if (bus.YACK) w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!bus.YACK) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = 32'd0;
        if (r_dp_vld && !r_dp_write) begin
            case (r_dp_off)
                2'd0:    w_rdata = {w_perr_cnt, 5'b0, w_pc75, w_pc50, w_pc25, w_occ8};
                2'd1:    w_rdata = {r_cycle_cnt, r_full_cnt};
                default: w_rdata = 32'd0;
            endcase
        end
    end

    assign bus.HREADYOUT = ~w_stall;
    assign bus.HRESP     = 1'b0;
    assign bus.HRDATA    = w_rdata;
    assign bus.YDATA     = w_head;
    assign bus.YREQ      = w_yreq;
    assign bus.YPARITY   = w_ypar;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
endmodule

// File: tb/tb_ahb_write_buffer.sv
// Directed bench for ahb_write_buffer (DEPTH=16); stimulus queues expected reads/pops, a negedge monitor compares.
// Parity scenario is built only with WBUF_PARITY_EN defined.
module tb_ahb_write_buffer;
    logic clk;
    logic HRESETn;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [31:0] q_y[$];
    logic [31:0] q_rd[$];
    logic        mon_rd_dp;

    ahb_write_buffer_if #(.DWIDTH(32)) bus ();

    ahb_write_buffer #(.DWIDTH(32), .AWIDTH(4)) dut (
        .clk     (clk),
        .HRESETn (HRESETn),
        .bus     (bus.slave)
    );

    assign bus.HREADY = bus.HREADYOUT;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Bus-side view of which data phase is a read.
    always @(posedge clk or negedge HRESETn) begin
        if (!HRESETn)        mon_rd_dp <= 1'b0;
        else if (bus.HREADY) mon_rd_dp <= bus.HSEL & bus.HTRANS[1] & ~bus.HWRITE;
    end

    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (HRESETn && mon_rd_dp && bus.HREADYOUT) begin
                if (q_rd.size() == 0) begin
                    n_checks++;
                    $display("FAIL rd_unexpected: got 0x%08h, expected no read", bus.HRDATA);
                end else begin
                    e = q_rd.pop_front();
                    chk("hrdata", bus.HRDATA, e);
                end
            end
            if (HRESETn && bus.YREQ && bus.YACK) begin
                if (q_y.size() == 0) begin
                    n_checks++;
                    $display("FAIL pop_unexpected: got pop of 0x%08h, expected none", bus.YDATA);
                end else begin
                    e = q_y.pop_front();
                    chk("ydata", bus.YDATA, e);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (!bus.HREADYOUT && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.HREADYOUT) chk(name, {31'd0, bus.HREADYOUT}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic ahb_wr(input logic [31:0] a, input logic [31:0] d);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b1;
        bus.HADDR  = a;
        if (a[3:2] == 2'd0) q_y.push_back(d);
        @(posedge clk);
        #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HWDATA = d;
        wait_ready("wr_ready_budget");
    endtask

    task automatic ahb_rd(input logic [31:0] a, input logic [31:0] exp);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b0;
        bus.HADDR  = a;
        q_rd.push_back(exp);
        @(posedge clk);
        #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        wait_ready("rd_ready_budget");
    endtask

    task automatic y_hs();
        int n = 0;
        while (!bus.YREQ && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        if (!bus.YREQ) chk("yreq_wait_budget", {31'd0, bus.YREQ}, 32'd1);
        bus.YACK = 1'b1;
        @(posedge clk);
        #1;
        bus.YACK = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_hreadyout"}, {31'd0, bus.HREADYOUT}, 32'd1);
        chk({tag, "_empty"},     {31'd0, bus.empty},     32'd1);
        chk({tag, "_full"},      {31'd0, bus.full},      32'd0);
        chk({tag, "_yreq"},      {31'd0, bus.YREQ},      32'd0);
        chk({tag, "_yparity"},   {31'd0, bus.YPARITY},   32'd0);
    endtask

    initial begin
        HRESETn    = 1'b0;
        bus.HSEL   = 1'b0;
        bus.HADDR  = 32'd0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'b010;
        bus.HWDATA = 32'd0;
        bus.YACK   = 1'b0;
        cyc(2);
        chk_reset_outs("rst");
        chk("rst_hresp", {31'd0, bus.HRESP}, 32'd0);
        HRESETn = 1'b1;
        cyc(1);

        // Reset state readback
        ahb_rd(32'h0, 32'h0000_0000);
        chk("post_rst_empty", {31'd0, bus.empty}, 32'd1);
        chk("post_rst_yreq",  {31'd0, bus.YREQ},  32'd0);

        // Four words, in-order delivery, YREQ one cycle after first push
        ahb_wr(32'h0, 32'h11);
        chk("yreq_at_push", {31'd0, bus.YREQ}, 32'd0);
        cyc(1);
        chk("yreq_after_push", {31'd0, bus.YREQ}, 32'd1);
        ahb_wr(32'h0, 32'h22);
        ahb_wr(32'h0, 32'h33);
        ahb_wr(32'h0, 32'h44);
        ahb_rd(32'h0, 32'h0000_0104);
        repeat (4) y_hs();
        ahb_rd(32'h0, 32'h0000_0000);
        chk("drain4_empty", {31'd0, bus.empty}, 32'd1);

        // Fill to DEPTH, then a stalled 17th write released by one pop
        for (int i = 0; i < 16; i++) ahb_wr(32'h0, 32'h100 + i);
        chk("fill_full",  {31'd0, bus.full},  32'd1);
        chk("fill_empty", {31'd0, bus.empty}, 32'd0);
        ahb_rd(32'h0, 32'h0000_0710);
        ahb_wr(32'h4, 32'h0);
        ahb_rd(32'h4, 32'h0001_0001);
        ahb_wr(32'h8, 32'hDEAD);
        fork
            ahb_wr(32'h0, 32'h170);
            begin
                cyc(2);
                chk("stall_hreadyout", {31'd0, bus.HREADYOUT}, 32'd0);
                y_hs();
            end
        join
        chk("after_stall_full", {31'd0, bus.full}, 32'd1);
        ahb_rd(32'h0, 32'h0000_0710);
        repeat (16) y_hs();
        chk("drain16_empty", {31'd0, bus.empty}, 32'd1);

        // YACK held high: one pop per REQ->RELEASE->IDLE round only
        ahb_wr(32'h0, 32'hA1);
        ahb_wr(32'h0, 32'hA2);
        ahb_wr(32'h0, 32'hA3);
        bus.YACK = 1'b1;
        cyc(6);
        chk("held_yreq_r1", {31'd0, bus.YREQ}, 32'd0);
        ahb_rd(32'h0, 32'h0000_0002);
        bus.YACK = 1'b0;
        cyc(1);
        bus.YACK = 1'b1;
        cyc(6);
        ahb_rd(32'h0, 32'h0000_0001);
        bus.YACK = 1'b0;
        cyc(1);
        bus.YACK = 1'b1;
        cyc(6);
        ahb_rd(32'h0, 32'h0000_0000);
        bus.YACK = 1'b0;
        cyc(1);
        bus.YACK = 1'b1;
        cyc(6);
        chk("held_empty_yreq", {31'd0, bus.YREQ},  32'd0);
        chk("held_empty",      {31'd0, bus.empty}, 32'd1);
        bus.YACK = 1'b0;
        cyc(1);

`ifdef WBUF_PARITY_EN
        // Corrupt bit 0 of the head entry; parity flags it and perr_cnt counts the pop
        ahb_wr(32'h0, 32'h5A);
        dut.r_mem[dut.r_rd_ptr][0] = ~dut.r_mem[dut.r_rd_ptr][0];
        q_y[q_y.size()-1] = 32'h5B;
        cyc(1);
        chk("par_yparity", {31'd0, bus.YPARITY}, 32'd1);
        y_hs();
        chk("par_yparity_idle", {31'd0, bus.YPARITY}, 32'd0);
        ahb_rd(32'h0, 32'h0001_0000);
        ahb_wr(32'h4, 32'h0);
        ahb_rd(32'h4, 32'h0001_0000);
        ahb_rd(32'h0, 32'h0000_0000);
`endif

        // Reset during a stalled write with YREQ up
        for (int i = 0; i < 16; i++) ahb_wr(32'h0, 32'h200 + i);
        fork
            ahb_wr(32'h0, 32'h2FF);
            begin
                cyc(2);
                chk("rst_stall_hreadyout", {31'd0, bus.HREADYOUT}, 32'd0);
                chk("rst_stall_yreq",      {31'd0, bus.YREQ},      32'd1);
                HRESETn = 1'b0;
                #1;
                chk_reset_outs("async_rst");
            end
        join
        q_y.delete();
        chk_reset_outs("held_rst");
        HRESETn  = 1'b1;
        bus.YACK = 1'b1;
        cyc(5);
        chk("post_rst_no_yreq",  {31'd0, bus.YREQ},  32'd0);
        chk("post_rst_empty2",   {31'd0, bus.empty}, 32'd1);
        bus.YACK = 1'b0;
        ahb_rd(32'h0, 32'h0000_0000);

        chk("q_y_leftover",  q_y.size(),  32'd0);
        chk("q_rd_leftover", q_rd.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ahb_write_buffer.md
AHB_WRITE_BUFFER -- requirements
Module: ahb_write_buffer

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, meaning payload width in bits (8..32).
REQ-002 SHALL have parameter AWIDTH, default 4, meaning log2 of depth (DEPTH = 2**AWIDTH, 2..7).
REQ-003 SHALL use reset HRESETn, asynchronous, active-low; clock clk.
REQ-004 SHALL have ports, each as name direction width meaning:
- clk in 1 clock
- HRESETn in 1 reset
- HSEL in 1 slave select
- HADDR in 32 address, bits [3:2] decoded
- HTRANS in 2 transfer type
- HWRITE in 1 write
- HSIZE in 3 size, ignored
- HREADY in 1 bus ready
- HWDATA in 32 write data, [DWIDTH-1:0] used
- HREADYOUT out 1 slave ready
- HRESP out 1 always 0 (OKAY)
- HRDATA out 32 read data
- YDATA out DWIDTH head entry
- YREQ out 1 consumer request
- YACK in 1 consumer acknowledge
- YPARITY out 1 head parity mismatch
- full out 1 occupancy == DEPTH
- empty out 1 occupancy == 0

Function
REQ-005 SHALL capture the address phase when HSEL & HREADY & HTRANS[1]; the action occurs in the following data phase.
REQ-006 SHALL push HWDATA[DWIDTH-1:0] on a data-phase write to offset 0x0.
REQ-007 SHALL hold HREADYOUT low during a 0x0 write data phase while full and no pop occurs that cycle; the push completes in the first cycle with space or a same-cycle pop.
REQ-008 SHALL clear all three counters on a data-phase write to offset 0x4; writes to 0x8/0xC SHALL be ignored; all such writes complete with zero wait states.
REQ-009 SHALL return zero-wait-state reads, HRDATA valid in the data phase:
- 0x0 {perr_cnt[15:0], 5'b0, pc75, pc50, pc25, occupancy[7:0]}
- 0x4 {cycle_cnt[15:0], full_cnt[15:0]}
- 0x8/0xC zero
REQ-010 SHALL keep occupancy as an AWIDTH+1-bit count, updated as +1 on push, -1 on pop, unchanged on simultaneous push and pop.
REQ-011 SHALL set pc25/pc50/pc75 when occupancy >= DEPTH/4, DEPTH/2, 3*DEPTH/4 respectively.
REQ-012 SHALL wrap read and write pointers modulo DEPTH.
REQ-013 SHALL increment cycle_cnt every clock, and full_cnt every clock with full high; both SHALL saturate at 0xFFFF.
REQ-014 SHALL run a consumer FSM with three states:
- IDLE: YREQ=0; go to REQ when !empty.
- REQ: YREQ=1; on YACK=1, pop the head and go to RELEASE.
- RELEASE: YREQ=0; return to IDLE when YACK=0.
REQ-015 SHALL drive YDATA from the head entry at all times; the value is undefined-but-stable when empty.
REQ-016 SHALL ignore YACK in IDLE and RELEASE; a pop SHALL never occur when empty.
REQ-017 SHALL use full = (occupancy == DEPTH) and empty = (occupancy == 0), both registered-state derived.

Reset
REQ-018 SHALL, on HRESETn low, asynchronously set the pointers, occupancy and all counters to 0, the FSM to IDLE, YREQ=0, YPARITY=0, HREADYOUT=1, empty=1, full=0.
REQ-019 SHALL discard any stalled write and in-flight handshake on reset; RAM contents SHALL need no reset.

Configuration
REQ-020 SHALL, with WBUF_PARITY_EN defined:
- store ^HWDATA[DWIDTH-1:0] as an extra bit per entry;
- drive YPARITY = (^YDATA ^ stored bit) while YREQ=1, else 0;
- increment perr_cnt (saturating) on each pop with YPARITY=1.
REQ-021 SHALL, with WBUF_PARITY_EN undefined, omit the extra storage bit, tie YPARITY to 0, and read perr_cnt as 0.

Verification
REQ-022 Reset then read 0x0 -> HRDATA=0x00000000; empty=1, YREQ=0.
REQ-023 Write 0x11..0x44 (4 words, DEPTH=16) -> occupancy=4, pc25=1; YREQ rises 1 cycle after the first push; four YACK pulses yield YDATA 0x11,0x22,0x33,0x44 in order.
REQ-024 Fill 16 words with YACK=0, then issue a 17th write -> full=1, HREADYOUT=0; one YACK handshake -> the write completes, occupancy stays 16.
REQ-025 Hold YACK=1 continuously with 3 entries -> exactly one pop per REQ->RELEASE->IDLE round, no pop while empty.
REQ-026 With WBUF_PARITY_EN, force-flip bit 0 of a stored entry -> YPARITY=1 while at head, perr_cnt=1 after its pop; then write 0x4 -> all counters read 0.
REQ-027 Assert HRESETn low during a stalled write with YREQ=1 -> outputs at reset values next cycle; no spurious pop after release.
